// File: rtl/even_result_pipe.sv
// Seven-stage even-pipe result shift register. It forwards operands youngest-first,
// stalls on unready matches, and writes results back to the register file from s7.
module even_result_pipe #(
  parameter int REG_ADDR_WD = 7,
  parameter int REG_DATA_WD = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic [REG_ADDR_WD-1:0] issue_rt_addr,
  input  logic [2:0]             issue_latency,
  input  logic [REG_DATA_WD-1:0] issue_RT,
  input  logic                   flush,
  input  logic [REG_ADDR_WD-1:0] ra_addr,
  input  logic [REG_ADDR_WD-1:0] rb_addr,
  input  logic [REG_ADDR_WD-1:0] rc_addr,
  input  logic [REG_DATA_WD-1:0] ra_rf,
  input  logic [REG_DATA_WD-1:0] rb_rf,
  input  logic [REG_DATA_WD-1:0] rc_rf,
  output logic [REG_DATA_WD-1:0] ra_fwd,
  output logic [REG_DATA_WD-1:0] rb_fwd,
  output logic [REG_DATA_WD-1:0] rc_fwd,
  output logic                   stall,
  output logic                   wb_en,
  output logic [REG_ADDR_WD-1:0] wb_addr,
  output logic [REG_DATA_WD-1:0] wb_data,
  output logic [REG_ADDR_WD-1:0] rf_addr_s2,
  output logic [REG_ADDR_WD-1:0] rf_addr_s3,
  output logic [REG_ADDR_WD-1:0] rf_addr_s4,
  output logic [REG_ADDR_WD-1:0] rf_addr_s5,
  output logic [REG_ADDR_WD-1:0] rf_addr_s6,
  output logic [REG_ADDR_WD-1:0] rf_addr_s7,
  output logic [REG_DATA_WD-1:0] rf_data_s2,
  output logic [REG_DATA_WD-1:0] rf_data_s3,
  output logic [REG_DATA_WD-1:0] rf_data_s4,
  output logic [REG_DATA_WD-1:0] rf_data_s5,
  output logic [REG_DATA_WD-1:0] rf_data_s6,
  output logic [REG_DATA_WD-1:0] rf_data_s7
);

  localparam int NS   = 7;
  localparam int NSRC = 3;

  logic [NS:1]            r_valid;
  logic [REG_ADDR_WD-1:0] r_addr [1:NS];
  logic [REG_DATA_WD-1:0] r_data [1:NS];
  logic [2:0]             r_lat  [1:NS];

  logic [NS:1]            w_ready;
  logic [2:0]             w_lat_clamped;
  logic [REG_ADDR_WD-1:0] w_src_addr [NSRC];
  logic [REG_DATA_WD-1:0] w_src_rf   [NSRC];
  logic [REG_DATA_WD-1:0] w_src_fwd  [NSRC];
  logic [NSRC-1:0]        w_src_stall;
  logic [NSRC-1:0]        w_src_found;

  // A 3-bit latency can never exceed 7, so only the low end needs clamping.
  assign w_lat_clamped = (issue_latency < 3'd2) ? 3'd2 : issue_latency;

  always_comb begin
    w_ready = '0;
    for (int k = 1; k <= NS; k++) begin
      w_ready[k] = r_valid[k] && (3'(k) >= r_lat[k]);
    end
  end

  assign w_src_addr[0] = ra_addr;
  assign w_src_addr[1] = rb_addr;
  assign w_src_addr[2] = rc_addr;
  assign w_src_rf[0]   = ra_rf;
  assign w_src_rf[1]   = rb_rf;
  assign w_src_rf[2]   = rc_rf;

  // The first valid address match, scanning youngest first, decides the outcome.
  // An older ready copy is never used past a younger unready one.
  always_comb begin
    w_src_fwd   = w_src_rf;
    w_src_stall = '0;
    w_src_found = '0;
    for (int s = 0; s < NSRC; s++) begin
      for (int k = 1; k <= NS; k++) begin
        if (!w_src_found[s] && r_valid[k] && (r_addr[k] == w_src_addr[s])) begin
          w_src_found[s] = 1'b1;
          if (w_ready[k]) begin
            w_src_fwd[s] = r_data[k];
          end else begin
            w_src_stall[s] = 1'b1;
          end
        end
      end
    end
  end

  assign ra_fwd = w_src_fwd[0];
  assign rb_fwd = w_src_fwd[1];
  assign rc_fwd = w_src_fwd[2];
  assign stall  = |w_src_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int k = 1; k <= NS; k++) begin
        r_addr[k] <= '0;
        r_data[k] <= '0;
        r_lat[k]  <= '0;
      end
    end else begin
      r_valid[1] <= issue_valid && !stall && !flush;
      r_addr[1]  <= issue_rt_addr;
      r_data[1]  <= issue_RT;
      r_lat[1]   <= w_lat_clamped;
      for (int k = 2; k <= NS; k++) begin
        r_valid[k] <= r_valid[k-1] && !flush;
        r_addr[k]  <= r_addr[k-1];
        r_data[k]  <= r_data[k-1];
        r_lat[k]   <= r_lat[k-1];
      end
    end
  end

  assign wb_en   = r_valid[7];
  assign wb_addr = r_addr[7];
  assign wb_data = r_data[7];

  assign rf_addr_s2 = r_valid[2] ? r_addr[2] : '0;
  assign rf_addr_s3 = r_valid[3] ? r_addr[3] : '0;
  assign rf_addr_s4 = r_valid[4] ? r_addr[4] : '0;
  assign rf_addr_s5 = r_valid[5] ? r_addr[5] : '0;
  assign rf_addr_s6 = r_valid[6] ? r_addr[6] : '0;
  assign rf_addr_s7 = r_valid[7] ? r_addr[7] : '0;

  assign rf_data_s2 = w_ready[2] ? r_data[2] : '0;
  assign rf_data_s3 = w_ready[3] ? r_data[3] : '0;
  assign rf_data_s4 = w_ready[4] ? r_data[4] : '0;
  assign rf_data_s5 = w_ready[5] ? r_data[5] : '0;
  assign rf_data_s6 = w_ready[6] ? r_data[6] : '0;
  assign rf_data_s7 = w_ready[7] ? r_data[7] : '0;

endmodule

// File: doc/even_result_pipe.md
EVEN_RESULT_PIPE -- requirements
Module: even_result_pipe

Interface
REQ-001 Parameter REG_ADDR_WD, default 7: register address width.
REQ-002 Parameter REG_DATA_WD, default 128: register data width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 issue_valid  input  1  an even-pipe result is presented this cycle.
REQ-006 issue_rt_addr  input  REG_ADDR_WD  destination register of the issued result.
REQ-007 issue_latency  input  3  result latency in stages; legal range 2..7.
REQ-008 issue_RT  input  REG_DATA_WD  result value from the even-pipe execute logic.
REQ-009 flush  input  1  synchronous kill of all in-flight results.
REQ-010 ra_addr, rb_addr, rc_addr  input  REG_ADDR_WD each  source operand addresses of the next instruction.
REQ-011 ra_rf, rb_rf, rc_rf  input  REG_DATA_WD each  register-file read data for those sources.
REQ-012 ra_fwd, rb_fwd, rc_fwd  output  REG_DATA_WD each  forwarded operand values.
REQ-013 stall  output  1  a source matches an in-flight result that is not yet ready.
REQ-014 wb_en, wb_addr, wb_data  output  1 / REG_ADDR_WD / REG_DATA_WD  register-file write port.
REQ-015 rf_addr_s2..rf_addr_s7  output  REG_ADDR_WD each  per-stage destination address.
REQ-016 rf_data_s2..rf_data_s7  output  REG_DATA_WD each  per-stage result data.

Function
REQ-017 The block SHALL hold seven stages, s1..s7; each stage holds valid, addr, data and latency.
REQ-018 On each clock edge, s1 SHALL load {issue_valid && !stall, issue_rt_addr, issue_RT, clamped latency}.
REQ-019 On the same edge, sk SHALL load s(k-1) for k = 2..7; the contents of s7 are dropped after write-back.
REQ-020 Latency clamping: a value below 2 SHALL be treated as 2, and a value above 7 SHALL be treated as 7.
REQ-021 Stage sk SHALL be ready when its valid bit is set and k >= its latency.
REQ-022 wb_en SHALL equal s7.valid, with wb_addr = s7.addr and wb_data = s7.data, combinationally; write-back latency from issue is therefore 7 cycles.
REQ-023 rf_addr_sk SHALL equal sk.addr when sk is valid, else 0.
REQ-024 rf_data_sk SHALL equal sk.data when sk is ready, else 0.
REQ-025 Forwarding for each source SHALL scan the stages youngest first (s1 to s7); the first valid stage whose addr equals the source address is the match.
REQ-026 If the match is ready, the forwarded output SHALL be that stage's data.
REQ-027 If the match is not ready, the forwarded output SHALL be the register-file data and stall SHALL be 1.
REQ-028 If no stage matches, the forwarded output SHALL be the register-file data.
REQ-029 An older ready match SHALL never override a younger unready match; the younger match governs and stall is raised.
REQ-030 stall SHALL be the OR over the three sources; it is combinational and has no registered delay.
REQ-031 While stall = 1, issue_valid SHALL be ignored and a bubble (valid = 0) SHALL enter s1, while the other stages keep advancing.
REQ-032 Write-back and forwarding of the same s7 entry in the same cycle SHALL both occur; the forwarded value equals wb_data.
REQ-033 flush SHALL clear every valid bit on the next edge, and any issue in the flush cycle SHALL be discarded; wb_en during the flush cycle still reflects s7.
REQ-034 Address 0 SHALL have no special meaning; all 2**REG_ADDR_WD addresses are forwardable.

Reset
REQ-035 While rst = 1, all stage valid, addr, data and latency fields SHALL be 0, asynchronously.
REQ-036 While rst = 1, wb_en, stall and all rf_addr_sk / rf_data_sk outputs SHALL be 0, and each forwarded output SHALL equal its register-file input.
REQ-037 Reset asserted mid-operation SHALL discard all in-flight results without write-back; operation resumes on the first edge after rst falls.

Verification
REQ-038 Issue addr 5, lat 2, RT 0xAA..AA; ra_addr = 5 -> cycle 1 stall = 1; cycle 2 ra_fwd = 0xAA..AA and stall = 0; cycle 7 wb_en = 1, wb_addr = 5.
REQ-039 Issue addr 9, lat 7, then addr 9, lat 2, one cycle apart; rb_addr = 9 -> stall until the younger entry reaches s2, then rb_fwd = the younger data, never the older.
REQ-040 Issue with lat 0 and lat 7 -> they behave as lat 2 and lat 7; rf_data_s3 = 0 for the lat-7 entry and equals its data for the clamped entry.
REQ-041 Hold issue_valid = 1 during a stall -> s1 receives a bubble; no duplicate write-back; the wb_en count equals the accepted issue count.
REQ-042 Fill s1..s7, then pulse flush -> on the next edge all rf_addr_sk = 0, and no wb_en for 7 cycles after.
REQ-043 Assert rst asynchronously between edges with 4 entries in flight -> outputs go to 0 immediately and no write-back follows.
